// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external dual-port block RAM: owns the read/write pointers,
// occupancy count and status flags, and re-times the RAM's one-cycle read latency.
module ram_fifo_ctrl #(
    parameter int MEM_WIDTH      = 16,
    parameter int ADDR_SIZE      = 10,
    parameter int ALMOST_FULL_TH = 1020
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [MEM_WIDTH-1:0] push_data,
    input  logic                 pop,
    output logic [MEM_WIDTH-1:0] pop_data,
    output logic                 pop_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic [MEM_WIDTH-1:0] ram_din,
    output logic [ADDR_SIZE-1:0] ram_addr_wr,
    output logic [ADDR_SIZE-1:0] ram_addr_rd,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic                 ram_blk_select,
    input  logic [MEM_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_SIZE:0]   DEPTH_C = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_SIZE:0]   AF_TH_C = (ADDR_SIZE + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_SIZE:0]   CNT_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE-1:0] PTR_ONE = {{(ADDR_SIZE - 1){1'b0}}, 1'b1};

    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic                 push_acc;
    logic                 pop_acc;

    // Handshake: push/pop are requests with no ready; a request is accepted in the cycle it is
    // high iff the FIFO is not full/empty (and not in reset). Rejected requests are dropped and
    // reported one cycle later on overflow/underflow. An accepted pop yields pop_valid=1 with
    // pop_data the next cycle. Reset gating keeps the RAM strobes quiet while rst is high.
    assign push_acc = push & ~full & ~rst;
    assign pop_acc  = pop & ~empty & ~rst;

    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_TH_C);

    assign ram_din        = push_data;
    assign ram_addr_wr    = wr_ptr;
    assign ram_addr_rd    = rd_ptr;
    assign ram_wr_en      = push_acc;
    assign ram_rd_en      = pop_acc;
    assign ram_blk_select = push_acc | pop_acc;
    assign pop_data       = ram_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
            // Simultaneous accepted push and pop leave the occupancy unchanged.
            case ({push_acc, pop_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            pop_valid <= pop_acc;
            overflow  <= push & full;
            underflow <= pop & empty;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: table of hand-computed vectors, then queue-checked sequences for
// fill-to-full, underflow, steady push+pop, pointer wrap and mid-stream reset.
module tb_ram_fifo_ctrl;

    localparam int W     = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [W-1:0]  push_data;
    logic          pop;
    logic [W-1:0]  pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic [W-1:0]  ram_din;
    logic [AW-1:0] ram_addr_wr;
    logic [AW-1:0] ram_addr_rd;
    logic          ram_wr_en;
    logic          ram_rd_en;
    logic          ram_blk_select;
    logic [W-1:0]  ram_dout;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [W-1:0]  exp_q[$];
    int            m_count;
    logic [AW-1:0] m_wr;
    logic [AW-1:0] m_rd;
    logic [W-1:0]  m_data;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.MEM_WIDTH(W), .ADDR_SIZE(AW), .ALMOST_FULL_TH(1020)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow),
        .ram_din(ram_din), .ram_addr_wr(ram_addr_wr), .ram_addr_rd(ram_addr_rd),
        .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_blk_select(ram_blk_select),
        .ram_dout(ram_dout)
    );

    // Behavioural block RAM with registered read
    logic [W-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_blk_select && ram_wr_en) mem[ram_addr_wr] <= ram_din;
        if (ram_blk_select && ram_rd_en) ram_dout <= mem[ram_addr_rd];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        push;
        logic        pop;
        logic [15:0] din;
        logic        exp_wr;
        logic        exp_rd;
        logic [10:0] exp_count;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_pv;
        logic [15:0] exp_data;
        logic        exp_ov;
        logic        exp_un;
    } vec_t;

    vec_t vecs[14];

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; push = v.push; pop = v.pop; push_data = v.din;
        #1;
        chk($sformatf("vec%0d wr_en", idx), ram_wr_en, v.exp_wr);
        chk($sformatf("vec%0d rd_en", idx), ram_rd_en, v.exp_rd);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d count", idx), count, v.exp_count);
        chk($sformatf("vec%0d empty", idx), empty, v.exp_empty);
        chk($sformatf("vec%0d full", idx), full, v.exp_full);
        chk($sformatf("vec%0d pop_valid", idx), pop_valid, v.exp_pv);
        if (v.exp_pv) chk($sformatf("vec%0d pop_data", idx), pop_data, v.exp_data);
        chk($sformatf("vec%0d overflow", idx), overflow, v.exp_ov);
        chk($sformatf("vec%0d underflow", idx), underflow, v.exp_un);
    endtask

    task automatic do_reset(input logic p, input logic q);
        @(negedge clk);
        rst = 1'b1; push = p; pop = q; push_data = 16'h1234;
        #1;
        chk("rst wr_en", ram_wr_en, 1'b0);
        chk("rst rd_en", ram_rd_en, 1'b0);
        chk("rst blk_select", ram_blk_select, 1'b0);
        @(posedge clk);
        #1;
        chk("rst count", count, 0);
        chk("rst empty", empty, 1'b1);
        chk("rst full", full, 1'b0);
        chk("rst almost_full", almost_full, 1'b0);
        chk("rst pop_valid", pop_valid, 1'b0);
        chk("rst overflow", overflow, 1'b0);
        chk("rst underflow", underflow, 1'b0);
        chk("rst addr_wr", ram_addr_wr, 0);
        chk("rst addr_rd", ram_addr_rd, 0);
        exp_q.delete();
        m_count = 0; m_wr = '0; m_rd = '0;
    endtask

    task automatic cyc(input logic p, input logic [W-1:0] d, input logic q);
        logic ap, aq;
        @(negedge clk);
        rst = 1'b0; push = p; push_data = d; pop = q;
        ap = p && (m_count != DEPTH);
        aq = q && (m_count != 0);
        #1;
        chk("wr_en", ram_wr_en, ap);
        chk("rd_en", ram_rd_en, aq);
        chk("blk_select", ram_blk_select, ap | aq);
        chk("addr_wr", ram_addr_wr, m_wr);
        chk("addr_rd", ram_addr_rd, m_rd);
        if (ap) chk("ram_din", ram_din, d);
        if (ap) begin
            exp_q.push_back(d);
            m_wr = m_wr + 1'b1;
        end
        if (aq) begin
            m_data = exp_q.pop_front();
            m_rd = m_rd + 1'b1;
        end
        m_count = m_count + int'(ap) - int'(aq);
        @(posedge clk);
        #1;
        chk("count", count, m_count);
        chk("empty", empty, m_count == 0);
        chk("full", full, m_count == DEPTH);
        chk("almost_full", almost_full, m_count >= 1020);
        chk("pop_valid", pop_valid, aq);
        if (aq) chk("pop_data", pop_data, m_data);
        chk("overflow", overflow, p && !ap);
        chk("underflow", underflow, q && !aq);
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        m_count = 0; m_wr = '0; m_rd = '0; m_data = '0;

        //          rst  push pop  din       wr   rd   cnt emp  ful  pv   data      ov   un
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) apply_vec(vecs[i], i);

        // Fill to full, reject one push, then full+push+pop, then drain
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'(i), 1'b0);
        cyc(1'b1, 16'h0400, 1'b0);
        cyc(1'b1, 16'hBEEF, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 16'h0000, 1'b1);

        // Underflow straight after reset
        do_reset(1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1);

        // Steady simultaneous push+pop at count 5
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 16'(16'h0200 + i), 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0000, 1'b1);

        // Pointer wrap with occupancy held at 3
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'(i), 1'b0);
        for (int i = 3; i < 1500; i++) cyc(1'b1, 16'(i), 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b1);

        // Reset the cycle after a pop at count 8, with requests held high during reset
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h0300 + i), 1'b0);
        cyc(1'b0, 16'h0000, 1'b1);
        do_reset(1'b1, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
